// File: rtl/amplitude_ram_arbiter_if.sv
// amplitude_ram_arbiter_if
//   Bundles the requester handshakes, requester RAM traffic and the shared
//   RAM port of the amplitude RAM arbiter.
//   Parameters: num_qubit (address width), complex_bit (half word width).
//   Modports:
//     slave  - arbiter side: takes req/release/traffic, drives grants, ram_*,
//              read_valid_*, ram_amplitude_busy, illegal_access.
//     master - requester/RAM side: the mirror image.
interface amplitude_ram_arbiter_if #(
   parameter int num_qubit   = 4,
   parameter int complex_bit = 24
);
   logic                       req_stab;
   logic                       release_stab;
   logic                       grant_stab;
   logic                       req_nonstab;
   logic                       release_nonstab;
   logic                       grant_nonstab;

   logic                       stab_read_en;
   logic [num_qubit-1:0]       stab_read_address;
   logic                       stab_write_en;
   logic [num_qubit-1:0]       stab_write_address;
   logic [2*complex_bit-1:0]   stab_write_data;

   logic                       nonstab_read_en;
   logic [num_qubit-1:0]       nonstab_read_address;
   logic                       nonstab_write_en;
   logic [num_qubit-1:0]       nonstab_write_address;
   logic [2*complex_bit-1:0]   nonstab_write_data;

   logic                       ram_read_en;
   logic [num_qubit-1:0]       ram_read_address;
   logic                       ram_write_en;
   logic [num_qubit-1:0]       ram_write_address;
   logic [2*complex_bit-1:0]   ram_write_data;

   logic                       read_valid_stab;
   logic                       read_valid_nonstab;
   logic                       ram_amplitude_busy;
   logic                       illegal_access;

   modport slave (
      input  req_stab, release_stab, req_nonstab, release_nonstab,
      input  stab_read_en, stab_read_address, stab_write_en,
             stab_write_address, stab_write_data,
      input  nonstab_read_en, nonstab_read_address, nonstab_write_en,
             nonstab_write_address, nonstab_write_data,
      output grant_stab, grant_nonstab,
      output ram_read_en, ram_read_address, ram_write_en,
             ram_write_address, ram_write_data,
      output read_valid_stab, read_valid_nonstab, ram_amplitude_busy,
             illegal_access
   );

   modport master (
      output req_stab, release_stab, req_nonstab, release_nonstab,
      output stab_read_en, stab_read_address, stab_write_en,
             stab_write_address, stab_write_data,
      output nonstab_read_en, nonstab_read_address, nonstab_write_en,
             nonstab_write_address, nonstab_write_data,
      input  grant_stab, grant_nonstab,
      input  ram_read_en, ram_read_address, ram_write_en,
             ram_write_address, ram_write_data,
      input  read_valid_stab, read_valid_nonstab, ram_amplitude_busy,
             illegal_access
   );
endinterface

// File: rtl/amplitude_ram_arbiter.sv
// amplitude_ram_arbiter
//   Grants exclusive burst ownership of the amplitude RAM to either the
//   stabilizer alpha stage (stab) or the nonstabilizer path (nonstab),
//   forwards only the owner's read/write traffic, tags read data back to the
//   owner one cycle after issue, and reports ram_amplitude_busy.
//   Ports:
//     clk  - single clock
//     rst  - asynchronous active-high reset
//     bus  - amplitude_ram_arbiter_if.slave (handshakes, traffic, RAM port)
//   Optional: define AMP_ARB_PROTECT_EN to make illegal_access a sticky flag
//   for non-owner accesses; otherwise illegal_access is tied to 0.
module amplitude_ram_arbiter #(
   parameter int num_qubit   = 4,
   parameter int complex_bit = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   amplitude_ram_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, OWN_S, OWN_N, DRAIN} state_t;

   state_t state;
   logic   last_nonstab;   // 1: nonstab owned most recently (tie goes to stab)
   logic   read_valid_stab_q;
   logic   read_valid_nonstab_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         last_nonstab         <= 1'b1;
         read_valid_stab_q    <= 1'b0;
         read_valid_nonstab_q <= 1'b0;
      end else begin
         read_valid_stab_q    <= bus.ram_read_en && (state == OWN_S);
         read_valid_nonstab_q <= bus.ram_read_en && (state == OWN_N);
         case (state)
            IDLE: begin
               if (bus.req_stab && (!bus.req_nonstab || last_nonstab))
                  state <= OWN_S;
               else if (bus.req_nonstab)
                  state <= OWN_N;
            end
            OWN_S: begin
               if (bus.release_stab) begin
                  state        <= DRAIN;
                  last_nonstab <= 1'b0;
               end
            end
            OWN_N: begin
               if (bus.release_nonstab) begin
                  state        <= DRAIN;
                  last_nonstab <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant_stab         = (state == OWN_S);
   assign bus.grant_nonstab      = (state == OWN_N);
   assign bus.ram_amplitude_busy = (state != IDLE);
   assign bus.read_valid_stab    = read_valid_stab_q;
   assign bus.read_valid_nonstab = read_valid_nonstab_q;

   always_comb begin
      bus.ram_read_en       = 1'b0;
      bus.ram_read_address  = '0;
      bus.ram_write_en      = 1'b0;
      bus.ram_write_address = '0;
      bus.ram_write_data    = '0;
      case (state)
         OWN_S: begin
            bus.ram_read_en       = bus.stab_read_en;
            bus.ram_read_address  = bus.stab_read_address;
            bus.ram_write_en      = bus.stab_write_en;
            bus.ram_write_address = bus.stab_write_address;
            bus.ram_write_data    = bus.stab_write_data;
         end
         OWN_N: begin
            bus.ram_read_en       = bus.nonstab_read_en;
            bus.ram_read_address  = bus.nonstab_read_address;
            bus.ram_write_en      = bus.nonstab_write_en;
            bus.ram_write_address = bus.nonstab_write_address;
            bus.ram_write_data    = bus.nonstab_write_data;
         end
         default: ;
      endcase
   end

`ifdef AMP_ARB_PROTECT_EN
   logic illegal_q;
   logic stab_violation;
   logic nonstab_violation;

   assign stab_violation    = (bus.stab_read_en || bus.stab_write_en) && (state != OWN_S);
   assign nonstab_violation = (bus.nonstab_read_en || bus.nonstab_write_en) && (state != OWN_N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         illegal_q <= 1'b0;
      else if (stab_violation || nonstab_violation)
         illegal_q <= 1'b1;
   end

   assign bus.illegal_access = illegal_q;
`else
   assign bus.illegal_access = 1'b0;
`endif

endmodule

// File: tb/tb_amplitude_ram_arbiter.sv
// tb_amplitude_ram_arbiter
//   Directed bench for amplitude_ram_arbiter: reset values, grant latency,
//   tie-break alternation, owner forwarding, non-owner blocking, read tags
//   (including the release cycle), DRAIN turnaround and async reset mid-burst.
module tb_amplitude_ram_arbiter;
   localparam int NQ = 4;
   localparam int CB = 24;

`ifdef AMP_ARB_PROTECT_EN
   localparam logic PROT = 1'b1;
`else
   localparam logic PROT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   amplitude_ram_arbiter_if #(.num_qubit(NQ), .complex_bit(CB)) bus ();

   amplitude_ram_arbiter #(.num_qubit(NQ), .complex_bit(CB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.req_stab = 0; bus.release_stab = 0;
      bus.req_nonstab = 0; bus.release_nonstab = 0;
      bus.stab_read_en = 0; bus.stab_read_address = '0;
      bus.stab_write_en = 0; bus.stab_write_address = '0; bus.stab_write_data = '0;
      bus.nonstab_read_en = 0; bus.nonstab_read_address = '0;
      bus.nonstab_write_en = 0; bus.nonstab_write_address = '0; bus.nonstab_write_data = '0;

      repeat (2) @(posedge clk);
      #2 rst = 0;
      #1;
      check_eq("rst_grant_stab", bus.grant_stab, 0);
      check_eq("rst_grant_nonstab", bus.grant_nonstab, 0);
      check_eq("rst_busy", bus.ram_amplitude_busy, 0);
      check_eq("rst_illegal", bus.illegal_access, 0);
      check_eq("rst_ram_read_en", bus.ram_read_en, 0);

      // Single stab request: grant one cycle later.
      bus.req_stab = 1;
      step();
      check_eq("s1_grant_stab", bus.grant_stab, 1);
      check_eq("s1_busy", bus.ram_amplitude_busy, 1);
      check_eq("s1_grant_nonstab", bus.grant_nonstab, 0);
      bus.req_stab = 0;

      // Owner read forwarding and tag.
      bus.stab_read_en = 1; bus.stab_read_address = 4'h5;
      #1;
      check_eq("rd_ram_read_en", bus.ram_read_en, 1);
      check_eq("rd_ram_read_addr", bus.ram_read_address, 5);
      step();
      bus.stab_read_en = 0;
      check_eq("rd_valid_stab", bus.read_valid_stab, 1);
      check_eq("rd_valid_nonstab", bus.read_valid_nonstab, 0);

      // Owner write forwarding; non-owner release ignored.
      bus.stab_write_en = 1; bus.stab_write_address = 4'h9;
      bus.stab_write_data = 48'hABCDEF123456;
      bus.release_nonstab = 1;
      #1;
      check_eq("wr_ram_write_en", bus.ram_write_en, 1);
      check_eq("wr_ram_write_addr", bus.ram_write_address, 9);
      check_eq("wr_ram_write_data", bus.ram_write_data, 48'hABCDEF123456);
      step();
      bus.stab_write_en = 0; bus.release_nonstab = 0;
      check_eq("nonowner_release_ignored", bus.grant_stab, 1);
      check_eq("illegal_before_violation", bus.illegal_access, 0);
      check_eq("rd_valid_cleared", bus.read_valid_stab, 0);

      // Non-owner write is blocked.
      bus.nonstab_write_en = 1; bus.nonstab_write_address = 4'h3;
      bus.nonstab_write_data = 48'h1;
      #1;
      check_eq("blk_ram_write_en", bus.ram_write_en, 0);
      step();
      bus.nonstab_write_en = 0;
      check_eq("blk_illegal", bus.illegal_access, PROT);

      // Read in release cycle: forwarded, tagged during DRAIN.
      bus.release_stab = 1; bus.stab_read_en = 1; bus.stab_read_address = 4'h7;
      #1;
      check_eq("rel_ram_read_en", bus.ram_read_en, 1);
      check_eq("rel_ram_read_addr", bus.ram_read_address, 7);
      step();
      bus.release_stab = 0;
      #1;
      check_eq("drain_valid_stab", bus.read_valid_stab, 1);
      check_eq("drain_ram_read_en", bus.ram_read_en, 0);
      check_eq("drain_busy", bus.ram_amplitude_busy, 1);
      check_eq("drain_grant_stab", bus.grant_stab, 0);
      bus.stab_read_en = 0;
      step();
      check_eq("idle_busy", bus.ram_amplitude_busy, 0);
      check_eq("idle_valid_stab", bus.read_valid_stab, 0);
      check_eq("illegal_sticky", bus.illegal_access, PROT);

      // Reset clears the sticky flag and restores last_owner = NONSTAB.
      rst = 1;
      #1;
      check_eq("rst2_illegal", bus.illegal_access, 0);
      @(posedge clk);
      #2 rst = 0;

      // Tie after reset goes to stab.
      bus.req_stab = 1; bus.req_nonstab = 1;
      step();
      check_eq("tie1_grant_stab", bus.grant_stab, 1);
      check_eq("tie1_grant_nonstab", bus.grant_nonstab, 0);
      bus.req_stab = 0; bus.release_stab = 1;
      step();
      bus.release_stab = 0;
      check_eq("tie1_drain_grant_n", bus.grant_nonstab, 0);
      check_eq("tie1_drain_busy", bus.ram_amplitude_busy, 1);
      step();
      check_eq("tie1_idle_busy", bus.ram_amplitude_busy, 0);
      check_eq("tie1_idle_grant_n", bus.grant_nonstab, 0);
      step();
      check_eq("tie1_grant_nonstab", bus.grant_nonstab, 1);

      // Nonstab releases; both request during DRAIN -> stab wins the next tie.
      bus.req_nonstab = 0; bus.release_nonstab = 1;
      step();
      bus.release_nonstab = 0;
      bus.req_stab = 1; bus.req_nonstab = 1;
      step();
      check_eq("tie2_idle_busy", bus.ram_amplitude_busy, 0);
      step();
      check_eq("tie2_grant_stab", bus.grant_stab, 1);
      check_eq("tie2_grant_nonstab", bus.grant_nonstab, 0);

      // Hand over to nonstab, then reset with a read in flight.
      bus.req_stab = 0; bus.release_stab = 1;
      step();
      bus.release_stab = 0;
      step();
      step();
      check_eq("n_grant_nonstab", bus.grant_nonstab, 1);
      bus.req_nonstab = 0;
      bus.nonstab_read_en = 1; bus.nonstab_read_address = 4'h2;
      #1;
      check_eq("n_ram_read_addr", bus.ram_read_address, 2);
      step();
      check_eq("n_valid_nonstab", bus.read_valid_nonstab, 1);
      check_eq("n_valid_stab", bus.read_valid_stab, 0);
      rst = 1;
      #1;
      check_eq("rstmid_grant_nonstab", bus.grant_nonstab, 0);
      check_eq("rstmid_busy", bus.ram_amplitude_busy, 0);
      check_eq("rstmid_valid_nonstab", bus.read_valid_nonstab, 0);
      check_eq("rstmid_ram_read_en", bus.ram_read_en, 0);
      bus.nonstab_read_en = 0;
      @(posedge clk);
      #2 rst = 0;

      // last_owner back to NONSTAB: a tie goes to stab.
      bus.req_stab = 1; bus.req_nonstab = 1;
      step();
      check_eq("tie3_grant_stab", bus.grant_stab, 1);
      check_eq("tie3_grant_nonstab", bus.grant_nonstab, 0);
      bus.req_stab = 0; bus.req_nonstab = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
